// File: rtl/icache_fill_responder_pkg.sv
// Shared types and line geometry for the I-cache fill responder and its miss queue.
`ifndef ICACHE_BITS_IN_LINE
`define ICACHE_BITS_IN_LINE 256
`endif
`ifndef ICACHE_TAG_BITS
`define ICACHE_TAG_BITS 21
`endif
`ifndef ICACHE_INDEX_BITS
`define ICACHE_INDEX_BITS 6
`endif
`ifndef ICACHE_BLOCK_ADDR_BITS
`define ICACHE_BLOCK_ADDR_BITS 27
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

package icache_fill_responder_pkg;

   localparam int LINE_BITS     = `ICACHE_BITS_IN_LINE;
   localparam int TAG_BITS      = `ICACHE_TAG_BITS;
   localparam int INDEX_BITS    = `ICACHE_INDEX_BITS;
   localparam int BLOCK_BITS    = `ICACHE_BLOCK_ADDR_BITS;
   localparam int PC_BITS       = `SIZE_PC;
   localparam int DEF_WORD_BITS = 64;

   // A single-beat line still keeps a 1-bit beat counter so widths never collapse to zero.
   function automatic int beat_bits(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int W         = LINE_BITS / DEF_WORD_BITS;
   localparam int BEAT_BITS = beat_bits(W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } fill_state_e;

   typedef struct packed {
      logic [TAG_BITS-1:0]   tag;
      logic [INDEX_BITS-1:0] index;
   } blk_addr_t;

endpackage

// File: rtl/icache_miss_queue.sv
// Circular FIFO of miss block addresses with a parallel match port for coalescing.
module icache_miss_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 27
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic          pop,
   output logic [AW-1:0] head,
   output logic          full,
   output logic          empty,
   input  logic [AW-1:0] match_addr,
   output logic          match,
   output logic          drop
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]    entry_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic [PW:0]      count_q;
   logic             accept;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (count_q == '0);
   assign full   = (count_q == (PW+1)'(DEPTH));
   // A full queue still takes a push when the head leaves in the same cycle.
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;
   assign head   = entry_q[rd_q];

   always_comb begin
      match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (entry_q[i] == match_addr)) match = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      end else begin
         if (pop) begin
            valid_q[rd_q] <= 1'b0;
            rd_q          <= ptr_inc(rd_q);
         end
         if (accept) begin
            entry_q[wr_q] <= push_addr;
            valid_q[wr_q] <= 1'b1;
            wr_q          <= ptr_inc(wr_q);
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/icache_fill_responder.sv
// Memory-side I-cache miss responder: queued, coalesced line reads returned as one fill pulse,
// with invalidations forwarded so a fill never overtakes an invalidation of its own line.
//   state   | meaning
//   S_IDLE  | waiting for a queued miss; pops it into the in-flight register
//   S_ISSUE | memRdReq_o held until granted for the current beat
//   S_WAIT  | waiting for read data of the current beat
//   S_RESP  | one-cycle fill pulse of the assembled line
module icache_fill_responder
   import icache_fill_responder_pkg::*;
#(
   parameter int WORD_BITS = DEF_WORD_BITS,
   parameter int REQ_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BLOCK_BITS-1:0] ic2memReqAddr_i,
   input  logic                  ic2memReqValid_i,
   input  logic                  ic2memReqWay_i,
   output logic [TAG_BITS-1:0]   mem2icTag_o,
   output logic [INDEX_BITS-1:0] mem2icIndex_o,
   output logic [LINE_BITS-1:0]  mem2icData_o,
   output logic                  mem2icRespValid_o,
   output logic                  mem2icInv_o,
   output logic [INDEX_BITS-1:0] mem2icInvInd_o,
   output logic                  mem2icInvWay_o,
   input  logic                  invReq_i,
   input  logic [INDEX_BITS-1:0] invIndex_i,
   output logic [PC_BITS-1:0]    memRdAddr_o,
   output logic                  memRdReq_o,
   input  logic                  memRdGnt_i,
   input  logic [WORD_BITS-1:0]  memRdData_i,
   input  logic                  memRdValid_i,
   output logic                  reqOverflow_o
);

   localparam int NUM_BEATS = LINE_BITS / WORD_BITS;
   localparam int BEAT_W    = beat_bits(NUM_BEATS);
   localparam int OFF_BITS  = $clog2(WORD_BITS / 8);
   localparam int RAW_BITS  = BLOCK_BITS + ((NUM_BEATS > 1) ? BEAT_W : 0) + OFF_BITS;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

   fill_state_e           state_q, state_d;
   blk_addr_t             inflight_q;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  refetch_q, refetch_d;
   logic [LINE_BITS-1:0]  line_q;
   logic                  inv_q;
   logic [INDEX_BITS-1:0] inv_ind_q;
   logic                  overflow_q;

   logic                  q_push, q_pop, q_full, q_empty, q_match, q_drop;
   logic [BLOCK_BITS-1:0] q_head;
   logic                  coalesce, inv_hit, refetch_any, beat_wr;
   logic [RAW_BITS-1:0]   rd_addr_raw;
   logic                  unused_way;

   assign unused_way = ic2memReqWay_i;

   assign coalesce = q_match ||
                     ((state_q != S_IDLE) && (ic2memReqAddr_i == BLOCK_BITS'(inflight_q)));
   assign q_push   = ic2memReqValid_i && !coalesce;
   assign q_pop    = (state_q == S_IDLE) && !q_empty;

   icache_miss_queue #(
      .DEPTH (REQ_DEPTH),
      .AW    (BLOCK_BITS)
   ) u_miss_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (q_push),
      .push_addr  (ic2memReqAddr_i),
      .pop        (q_pop),
      .head       (q_head),
      .full       (q_full),
      .empty      (q_empty),
      .match_addr (ic2memReqAddr_i),
      .match      (q_match),
      .drop       (q_drop)
   );

   // An invalidation arriving alongside the last beat must still force the re-read.
   assign inv_hit     = invReq_i && ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                        (invIndex_i == inflight_q.index);
   assign refetch_any = refetch_q || inv_hit;

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      refetch_d = refetch_any;
      beat_wr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!q_empty) begin
               state_d   = S_ISSUE;
               beat_d    = '0;
               refetch_d = 1'b0;
            end
         end
         S_ISSUE: begin
            if (memRdGnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (memRdValid_i) begin
               beat_wr = 1'b1;
               if (beat_q == LAST_BEAT) begin
                  if (refetch_any) begin
                     refetch_d = 1'b0;
                     beat_d    = '0;
                     state_d   = S_ISSUE;
                  end else begin
                     state_d   = S_RESP;
                  end
               end else begin
                  beat_d  = beat_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         refetch_q  <= 1'b0;
         inflight_q <= '0;
         line_q     <= '0;
         inv_q      <= 1'b0;
         inv_ind_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         refetch_q <= refetch_d;
         inv_q     <= invReq_i;
         inv_ind_q <= invIndex_i;
         if (q_pop) inflight_q <= blk_addr_t'(q_head);
         if (q_drop) overflow_q <= 1'b1;
         if (beat_wr) begin
            for (int k = 0; k < NUM_BEATS; k++) begin
               if (beat_q == BEAT_W'(k)) line_q[k*WORD_BITS +: WORD_BITS] <= memRdData_i;
            end
         end
      end
   end

   generate
      if (NUM_BEATS > 1) begin : g_multi_beat
         assign rd_addr_raw = {inflight_q, beat_q, {OFF_BITS{1'b0}}};
      end else begin : g_single_beat
         assign rd_addr_raw = {inflight_q, {OFF_BITS{1'b0}}};
      end
   endgenerate

   assign memRdAddr_o       = PC_BITS'(rd_addr_raw);
   assign memRdReq_o        = (state_q == S_ISSUE);
   assign mem2icRespValid_o = (state_q == S_RESP);
   assign mem2icTag_o       = inflight_q.tag;
   assign mem2icIndex_o     = inflight_q.index;
   assign mem2icData_o      = line_q;
   assign mem2icInv_o       = inv_q;
   assign mem2icInvInd_o    = inv_ind_q;
   assign mem2icInvWay_o    = 1'b0;
   assign reqOverflow_o     = overflow_q;

endmodule

// File: tb/tb_icache_fill_responder.sv
// Directed and randomized bench for icache_fill_responder against a simple line-read memory model.
`ifndef ICACHE_BITS_IN_LINE
`define ICACHE_BITS_IN_LINE 256
`endif
`ifndef ICACHE_TAG_BITS
`define ICACHE_TAG_BITS 21
`endif
`ifndef ICACHE_INDEX_BITS
`define ICACHE_INDEX_BITS 6
`endif
`ifndef ICACHE_BLOCK_ADDR_BITS
`define ICACHE_BLOCK_ADDR_BITS 27
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif

module tb_icache_fill_responder;
   import icache_fill_responder_pkg::*;

   localparam int WB = 64;
   localparam int NB = LINE_BITS / WB;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [BLOCK_BITS-1:0] ic2memReqAddr_i = '0;
   logic                  ic2memReqValid_i = 1'b0;
   logic                  ic2memReqWay_i = 1'b0;
   logic [TAG_BITS-1:0]   mem2icTag_o;
   logic [INDEX_BITS-1:0] mem2icIndex_o;
   logic [LINE_BITS-1:0]  mem2icData_o;
   logic                  mem2icRespValid_o;
   logic                  mem2icInv_o;
   logic [INDEX_BITS-1:0] mem2icInvInd_o;
   logic                  mem2icInvWay_o;
   logic                  invReq_i = 1'b0;
   logic [INDEX_BITS-1:0] invIndex_i = '0;
   logic [PC_BITS-1:0]    memRdAddr_o;
   logic                  memRdReq_o;
   logic                  memRdGnt_i = 1'b0;
   logic [WB-1:0]         memRdData_i;
   logic                  memRdValid_i;
   logic                  reqOverflow_o;

   logic                  mem_valid_m = 1'b0;
   logic [WB-1:0]         mem_data_m = '0;
   logic                  stray = 1'b0;
   int                    gnt_mode = 1;   // 0 never grant, 1 always, 2 random
   int                    cyc = 0;
   int                    passed = 0;
   int                    failed = 0;
   int                    total = 0;

   typedef struct {
      int                    cyc;
      logic [TAG_BITS-1:0]   tag;
      logic [INDEX_BITS-1:0] idx;
      logic [LINE_BITS-1:0]  data;
   } fill_t;

   fill_t                 fills[$];
   int                    inv_cyc[$];
   logic [INDEX_BITS-1:0] inv_idx[$];
   logic [PC_BITS-1:0]    reads[$];

   assign memRdValid_i = mem_valid_m | stray;
   assign memRdData_i  = stray ? 64'hDEAD_BEEF_DEAD_BEEF : mem_data_m;

   icache_fill_responder #(.WORD_BITS(WB), .REQ_DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .ic2memReqAddr_i   (ic2memReqAddr_i),
      .ic2memReqValid_i  (ic2memReqValid_i),
      .ic2memReqWay_i    (ic2memReqWay_i),
      .mem2icTag_o       (mem2icTag_o),
      .mem2icIndex_o     (mem2icIndex_o),
      .mem2icData_o      (mem2icData_o),
      .mem2icRespValid_o (mem2icRespValid_o),
      .mem2icInv_o       (mem2icInv_o),
      .mem2icInvInd_o    (mem2icInvInd_o),
      .mem2icInvWay_o    (mem2icInvWay_o),
      .invReq_i          (invReq_i),
      .invIndex_i        (invIndex_i),
      .memRdAddr_o       (memRdAddr_o),
      .memRdReq_o        (memRdReq_o),
      .memRdGnt_i        (memRdGnt_i),
      .memRdData_i       (memRdData_i),
      .memRdValid_i      (memRdValid_i),
      .reqOverflow_o     (reqOverflow_o)
   );

   always #5 clk = ~clk;

   function automatic logic [WB-1:0] mem_word(input logic [PC_BITS-1:0] a);
      return {a ^ 32'hA5A5_0F0F, ~a};
   endfunction

   function automatic logic [PC_BITS-1:0] byte_addr(input logic [BLOCK_BITS-1:0] b, input int k);
      return PC_BITS'(b) * PC_BITS'(LINE_BITS / 8) + PC_BITS'(k * (WB / 8));
   endfunction

   function automatic logic [LINE_BITS-1:0] exp_line(input logic [BLOCK_BITS-1:0] b);
      logic [LINE_BITS-1:0] l;
      l = '0;
      for (int k = 0; k < NB; k++) l[k*WB +: WB] = mem_word(byte_addr(b, k));
      return l;
   endfunction

   function automatic fill_t get_fill(input int i);
      fill_t f;
      f = '{-1, 'x, 'x, 'x};
      if (i < fills.size()) f = fills[i];
      return f;
   endfunction

   function automatic int exp_tag(input logic [BLOCK_BITS-1:0] b);
      return int'(b) >> INDEX_BITS;
   endfunction

   function automatic int exp_idx(input logic [BLOCK_BITS-1:0] b);
      return int'(b) % (1 << INDEX_BITS);
   endfunction

   // Cycle counter, advanced on the active edge; everything else samples on the falling edge.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Backing memory: same-cycle grant per gnt_mode, data one cycle after the grant. Also logs outputs.
   initial begin
      logic                pend;
      logic [PC_BITS-1:0]  paddr;
      pend  = 1'b0;
      paddr = '0;
      forever begin
         @(negedge clk);
         mem_valid_m = pend;
         mem_data_m  = pend ? mem_word(paddr) : '0;
         pend        = 1'b0;
         case (gnt_mode)
            0:       memRdGnt_i = 1'b0;
            1:       memRdGnt_i = 1'b1;
            default: memRdGnt_i = 1'($urandom_range(0, 1));
         endcase
         if (memRdReq_o && memRdGnt_i) begin
            pend  = 1'b1;
            paddr = memRdAddr_o;
            reads.push_back(memRdAddr_o);
         end
         if (mem2icRespValid_o) fills.push_back('{cyc, mem2icTag_o, mem2icIndex_o, mem2icData_o});
         if (mem2icInv_o) begin
            inv_cyc.push_back(cyc);
            inv_idx.push_back(mem2icInvInd_o);
         end
      end
   end

   task automatic checkv(input string tag, input logic [LINE_BITS-1:0] obs,
                         input logic [LINE_BITS-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_req(input logic [BLOCK_BITS-1:0] a, output int c);
      ic2memReqAddr_i  = a;
      ic2memReqValid_i = 1'b1;
      c = cyc;
      @(negedge clk);
      ic2memReqValid_i = 1'b0;
   endtask

   task automatic wait_fills(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (fills.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checki(tag, fills.size(), n);
   endtask

   task automatic check_idle_outputs(input string tag);
      checki({tag, "_strobes"}, int'({mem2icRespValid_o, memRdReq_o, mem2icInv_o, reqOverflow_o}), 0);
      checkv({tag, "_data"}, mem2icData_o, '0);
      checki({tag, "_tagidx"}, int'({mem2icTag_o, mem2icIndex_o}), 0);
      checki({tag, "_addr"}, int'(memRdAddr_o), 0);
   endtask

   initial begin
      int                    c;
      int                    c2;
      int                    guard;
      fill_t                 f;
      logic [BLOCK_BITS-1:0] a;
      logic [BLOCK_BITS-1:0] ov_addr[6];
      logic [BLOCK_BITS-1:0] rnd_addr[$];

      // Reset state
      tick(3);
      check_idle_outputs("rst");
      checki("rst_invway", int'(mem2icInvWay_o), 0);
      reset = 1'b1;
      tick(2);

      // Single miss: 4 beats, fill at t+10
      fills.delete();
      reads.delete();
      send_req(27'h1A3, c);
      wait_fills("t1_fill_count", 1, 40);
      f = get_fill(0);
      checki("t1_fill_cycle", f.cyc, c + 10);
      checki("t1_tag", int'(f.tag), exp_tag(27'h1A3));
      checki("t1_index", int'(f.idx), exp_idx(27'h1A3));
      checkv("t1_data", f.data, exp_line(27'h1A3));
      checki("t1_reads", reads.size(), NB);
      for (int k = 0; k < NB; k++)
         checki($sformatf("t1_rdaddr%0d", k), (k < reads.size()) ? int'(reads[k]) : -1,
                int'(byte_addr(27'h1A3, k)));
      tick(2);
      checki("t1_resp_pulse", int'(mem2icRespValid_o), 0);

      // Duplicate strobes coalesce into one fill
      fills.delete();
      gnt_mode = 0;
      send_req(27'h40, c);
      tick(2);
      send_req(27'h40, c2);
      tick(16);
      send_req(27'h40, c2);
      gnt_mode = 1;
      wait_fills("t2_fill_wait", 1, 60);
      tick(30);
      checki("t2_single_fill", fills.size(), 1);
      checki("t2_fill_addr", int'({get_fill(0).tag, get_fill(0).idx}), 32'h40);
      checki("t2_no_overflow", int'(reqOverflow_o), 0);

      // Overflow: one in flight, four queued, sixth dropped
      fills.delete();
      gnt_mode = 0;
      for (int i = 0; i < 6; i++) begin
         ov_addr[i] = BLOCK_BITS'(27'h100 + i * 37);
         send_req(ov_addr[i], c);
      end
      tick(3);
      checki("t3_overflow", int'(reqOverflow_o), 1);
      gnt_mode = 1;
      wait_fills("t3_fill_wait", 5, 200);
      tick(20);
      checki("t3_fill_count", fills.size(), 5);
      for (int i = 0; i < 5; i++) begin
         f = get_fill(i);
         checki($sformatf("t3_order%0d", i), int'({f.tag, f.idx}), int'(ov_addr[i]));
         checkv($sformatf("t3_data%0d", i), f.data, exp_line(ov_addr[i]));
      end

      // Invalidation of the in-flight index during beat 2 forces a full re-read
      fills.delete();
      reads.delete();
      inv_cyc.delete();
      inv_idx.delete();
      a = 27'h2C7;
      send_req(a, c);
      tick(5);
      invReq_i   = 1'b1;
      invIndex_i = a[INDEX_BITS-1:0];
      tick(1);
      invReq_i   = 1'b0;
      wait_fills("t4_fill_wait", 1, 60);
      tick(2);
      checki("t4_inv_count", inv_cyc.size(), 1);
      checki("t4_inv_cycle", (inv_cyc.size() > 0) ? inv_cyc[0] : -1, c + 7);
      checki("t4_inv_index", (inv_idx.size() > 0) ? int'(inv_idx[0]) : -1, exp_idx(a));
      checki("t4_reads", reads.size(), 2 * NB);
      for (int k = 0; k < 2 * NB; k++)
         checki($sformatf("t4_rdaddr%0d", k), (k < reads.size()) ? int'(reads[k]) : -1,
                int'(byte_addr(a, k % NB)));
      f = get_fill(0);
      checki("t4_fill_cycle", f.cyc, c + 18);
      checkv("t4_data", f.data, exp_line(a));

      // Reset during WAIT, stray read data afterwards
      fills.delete();
      send_req(27'h3F0, c);
      tick(2);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
      stray = 1'b1;
      tick(1);
      stray = 1'b0;
      tick(15);
      checki("t5_no_fill", fills.size(), 0);
      check_idle_outputs("t5_post_reset");
      send_req(27'h155, c);
      wait_fills("t5_fill_count", 1, 40);
      f = get_fill(0);
      checki("t5_fill_cycle", f.cyc, c + 10);
      checki("t5_fill_addr", int'({f.tag, f.idx}), 32'h155);
      checkv("t5_data", f.data, exp_line(27'h155));

      // Random distinct misses under random grants: fills in request order with correct lines
      fills.delete();
      gnt_mode = 2;
      for (int i = 0; i < 24; i++) begin
         logic dup;
         do begin
            a   = BLOCK_BITS'($urandom());
            dup = 1'b0;
            foreach (rnd_addr[j]) if (rnd_addr[j] == a) dup = 1'b1;
         end while (dup);
         guard = 0;
         while ((rnd_addr.size() - fills.size()) >= 3 && guard < 500) begin
            tick(1);
            guard++;
         end
         rnd_addr.push_back(a);
         send_req(a, c);
         tick($urandom_range(0, 6));
      end
      wait_fills("rnd_fill_count", 24, 3000);
      for (int i = 0; i < 24; i++) begin
         f = get_fill(i);
         checki($sformatf("rnd_addr%0d", i), int'({f.tag, f.idx}), int'(rnd_addr[i]));
         checkv($sformatf("rnd_data%0d", i), f.data, exp_line(rnd_addr[i]));
      end
      checki("rnd_no_overflow", int'(reqOverflow_o), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
